// File: rtl/vdp_pkg.sv
// Shared VDP types: VRAM grant owner encoding and arbiter defaults.
// The owner/we pair travels down the arbiter pipeline to steer the return strobes.
package vdp_pkg;

  localparam int DEF_STARVE_LIMIT = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } own_t;

  typedef struct packed {
    own_t own;
    logic we;
  } stage_t;

endpackage

// File: rtl/vdp_vram_arbiter_if.sv
// Requester and VRAM-side signals of the VDP VRAM arbiter.
// slave = arbiter view; master = requesters plus VRAM macro view.
interface vdp_vram_arbiter_if #(
  parameter int ADDR_W = 14
);

  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_valid;

  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic [ADDR_W-1:0] vram_a;
  logic              vram_we;
  logic [7:0]        vram_wdata;
  logic [7:0]        vram_d;

  modport slave (
    input  bg_req, bg_addr, spr_req, spr_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_d,
    output bg_valid, spr_valid, cpu_ack, cpu_rdata,
    output vram_a, vram_we, vram_wdata
  );

  modport master (
    output bg_req, bg_addr, spr_req, spr_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_d,
    input  bg_valid, spr_valid, cpu_ack, cpu_rdata,
    input  vram_a, vram_we, vram_wdata
  );

endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: bg > spr > cpu, CPU promoted over spr once starved.
// Request-to-strobe latency is 2 cycles; bg is never stalled, spr/cpu wait for free slots.
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  vdp_vram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  own_t              gnt;
  logic              cpu_ok;
  logic              starved;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cpu_pend;
  logic              cpu_hold;
  stage_t            st1;
  stage_t            st2;
  logic [ADDR_W-1:0] vram_a_q;
  logic              vram_we_q;
  logic [7:0]        vram_wdata_q;
  logic [7:0]        rdata_q;
  logic              ack_rd;

  // cpu_hold blocks a second grant while the same request stays high after its ack
  assign cpu_ok  = bus.cpu_req && !cpu_pend && !cpu_hold;
  assign starved = starve_cnt >= CNT_W'(STARVE_LIMIT);

  always_comb begin
    gnt = OWN_NONE;
    if (bus.bg_req) begin
      gnt = OWN_BG;
    end else if (cpu_ok && starved) begin
      gnt = OWN_CPU;
    end else if (bus.spr_req) begin
      gnt = OWN_SPR;
    end else if (cpu_ok) begin
      gnt = OWN_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st1          <= '{own: OWN_NONE, we: 1'b0};
      st2          <= '{own: OWN_NONE, we: 1'b0};
      vram_a_q     <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
      rdata_q      <= '0;
      starve_cnt   <= '0;
      cpu_pend     <= 1'b0;
      cpu_hold     <= 1'b0;
    end else begin
      st1       <= '{own: gnt, we: (gnt == OWN_CPU) && bus.cpu_we};
      st2       <= st1;
      vram_we_q <= (gnt == OWN_CPU) && bus.cpu_we;

      case (gnt)
        OWN_BG:  vram_a_q <= bus.bg_addr;
        OWN_SPR: vram_a_q <= bus.spr_addr;
        OWN_CPU: begin
          vram_a_q <= bus.cpu_addr;
          if (bus.cpu_we) begin
            vram_wdata_q <= bus.cpu_wdata;
          end
        end
        default: ;
      endcase

      if (gnt == OWN_CPU) begin
        cpu_pend   <= 1'b1;
        starve_cnt <= '0;
      end else begin
        if (st2.own == OWN_CPU) begin
          cpu_pend <= 1'b0;
        end
        if (cpu_ok && !starved) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end

      cpu_hold <= (cpu_hold || (st2.own == OWN_CPU)) && bus.cpu_req;

      if (ack_rd) begin
        rdata_q <= bus.vram_d;
      end
    end
  end

  // read data arrives with the ack cycle, so it is passed through then held
  assign ack_rd         = (st2.own == OWN_CPU) && !st2.we;
  assign bus.bg_valid   = (st2.own == OWN_BG);
  assign bus.spr_valid  = (st2.own == OWN_SPR);
  assign bus.cpu_ack    = (st2.own == OWN_CPU);
  assign bus.cpu_rdata  = ack_rd ? bus.vram_d : rdata_q;
  assign bus.vram_a     = vram_a_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Randomized bench for vdp_vram_arbiter with a cycle-level reference model
// and a synchronous-read VRAM behavioural model.
module tb_vdp_vram_arbiter;
  import vdp_pkg::*;

  localparam int AW  = 14;
  localparam int LIM = 32;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vdp_vram_arbiter_if #(.ADDR_W(AW)) bus ();

  vdp_vram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // VRAM: one-cycle registered read, write on vram_we
  logic [7:0] mem     [0:(1<<AW)-1];
  bit         written [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.vram_we === 1'b1) begin
      mem[bus.vram_a]     <= bus.vram_wdata;
      written[bus.vram_a] <= 1'b1;
    end
    bus.vram_d <= written[bus.vram_a] ? mem[bus.vram_a] : init_val(bus.vram_a);
  end

  typedef struct {
    own_t          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    val;
  } ref_t;

  logic [7:0]    ref_mem [int];
  ref_t          g1, g2;
  logic [AW-1:0] exp_a;
  logic [7:0]    exp_rdata;
  bit            known, serviced, prev_req, ack_seen;
  int            cyc, rise, ack_cyc;
  int            total, bad;
  int            n_ack, n_we, n_sprv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic ref_t no_grant();
    ref_t r;
    r.own = OWN_NONE; r.we = 1'b0; r.addr = '0; r.val = '0;
    return r;
  endfunction

  // Checks this cycle's outputs, then decides who the spec says owns this cycle.
  task automatic model_cycle();
    ref_t g0;
    bit   elig, starved;
    if (known) begin
      check("bg_valid",  32'(bus.bg_valid),  32'(g2.own == OWN_BG));
      check("spr_valid", 32'(bus.spr_valid), 32'(g2.own == OWN_SPR));
      check("cpu_ack",   32'(bus.cpu_ack),   32'(g2.own == OWN_CPU));
      check("vram_a",    32'(bus.vram_a),    32'(exp_a));
      check("vram_we",   32'(bus.vram_we),   32'(g1.own == OWN_CPU && g1.we));
      if (g1.own == OWN_CPU && g1.we) check("vram_wdata", 32'(bus.vram_wdata), 32'(g1.val));
      if (g2.own == OWN_BG || g2.own == OWN_SPR) check("vram_d", 32'(bus.vram_d), 32'(g2.val));
      if (g2.own == OWN_CPU && !g2.we) exp_rdata = g2.val;
      check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
    end
    ack_seen = (bus.cpu_ack === 1'b1);
    if (ack_seen) begin n_ack++; ack_cyc = cyc; end
    if (bus.vram_we === 1'b1) n_we++;
    if (bus.spr_valid === 1'b1) n_sprv++;

    g0 = no_grant();
    if (rst) begin
      g1 = no_grant(); g2 = no_grant();
      exp_a = '0; exp_rdata = '0;
      serviced = 0; prev_req = 0; known = 1;
    end else begin
      if (bus.cpu_req && !prev_req) rise = cyc;
      if (!bus.cpu_req) serviced = 0;
      elig    = bus.cpu_req && !serviced;
      starved = (cyc - rise) >= LIM;
      if (bus.bg_req) begin
        g0.own = OWN_BG; g0.addr = bus.bg_addr;
      end else if (elig && starved) begin
        g0.own = OWN_CPU;
      end else if (bus.spr_req) begin
        g0.own = OWN_SPR; g0.addr = bus.spr_addr;
      end else if (elig) begin
        g0.own = OWN_CPU;
      end
      if (g0.own == OWN_CPU) begin
        serviced = 1;
        g0.addr  = bus.cpu_addr;
        g0.we    = bus.cpu_we;
        if (bus.cpu_we) begin
          g0.val = bus.cpu_wdata;
          ref_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
        end else begin
          g0.val = ref_rd(bus.cpu_addr);
        end
      end else if (g0.own != OWN_NONE) begin
        g0.val = ref_rd(g0.addr);
      end
      if (g0.own != OWN_NONE) exp_a = g0.addr;
      prev_req = bus.cpu_req;
      g2 = g1;
      g1 = g0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.bg_req = 0; bus.bg_addr = '0;
    bus.spr_req = 0; bus.spr_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                            output int lat);
    int start;
    bit done;
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    start = cyc; done = 0; lat = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (ack_seen) done = 1;
    end
    bus.cpu_req = 0;
    if (done) lat = ack_cyc - start;
    else check("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, a0, w0, s0, start;
    bit done;
    total = 0; bad = 0; cyc = 0; rise = 0; ack_cyc = 0;
    known = 0; serviced = 0; prev_req = 0; ack_seen = 0;
    n_ack = 0; n_we = 0; n_sprv = 0;
    g1 = no_grant(); g2 = no_grant(); exp_a = '0; exp_rdata = '0;
    rst = 1; idle();
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 0;

    check("rst_vram_a",     32'(bus.vram_a),     32'd0);
    check("rst_vram_we",    32'(bus.vram_we),    32'd0);
    check("rst_vram_wdata", 32'(bus.vram_wdata), 32'd0);
    check("rst_bg_valid",   32'(bus.bg_valid),   32'd0);
    check("rst_spr_valid",  32'(bus.spr_valid),  32'd0);
    check("rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
    check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);

    // single bg read granted right after reset
    bus.bg_req = 1; bus.bg_addr = 14'h0100;
    tick();
    idle();
    check("bg_vram_a", 32'(bus.vram_a), 32'h0100);
    tick();
    check("bg_valid_t2", 32'(bus.bg_valid), 32'd1);
    check("bg_data", 32'(bus.vram_d), 32'(init_val(14'h0100)));
    repeat (2) tick();

    // CPU write then read-back
    w0 = n_we;
    cpu_access(1'b1, 14'h3F00, 8'hA5, lat);
    repeat (3) tick();
    check("wr_pulses", 32'(n_we - w0), 32'd1);
    check("wr_latency", 32'(lat), 32'd2);
    cpu_access(1'b0, 14'h3F00, 8'h00, lat);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data", 32'(bus.cpu_rdata), 32'hA5);
    repeat (2) tick();

    // bg + spr saturating the port: CPU never granted while bg is high
    bus.bg_req = 1; bus.spr_req = 1; bus.bg_addr = 14'h0200; bus.spr_addr = 14'h0300;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'h3F00;
    a0 = n_ack;
    repeat (60) tick();
    check("bg_blocks_cpu", 32'(n_ack - a0), 32'd0);
    bus.bg_req = 0;
    start = cyc; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (ack_seen) done = 1;
    end
    check("starved_cpu_ack", 32'(done), 32'd1);
    check("starved_over_spr_lat", 32'(ack_cyc - start), 32'd2);
    idle();
    repeat (3) tick();

    // spr held: CPU waits exactly LIM cycles, then spr resumes
    bus.spr_req = 1; bus.spr_addr = 14'h0040;
    cpu_access(1'b0, 14'h0123, 8'h00, lat);
    check("starve_latency", 32'(lat), 32'(LIM + 2));
    s0 = n_sprv;
    repeat (4) tick();
    check("spr_resumes", 32'(n_sprv - s0), 32'd4);
    idle();
    repeat (3) tick();

    // held CPU request gets exactly one grant
    a0 = n_ack; w0 = n_we;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'h0010; bus.cpu_wdata = 8'h3C;
    repeat (10) tick();
    idle();
    repeat (4) tick();
    check("held_one_ack", 32'(n_ack - a0), 32'd1);
    check("held_one_we",  32'(n_we - w0),  32'd1);

    // reset one cycle after a spr grant kills the in-flight strobe
    bus.spr_req = 1; bus.spr_addr = 14'h0055;
    tick();
    idle();
    rst = 1;
    tick();
    rst = 0;
    check("rst2_vram_a",    32'(bus.vram_a),    32'd0);
    check("rst2_vram_we",   32'(bus.vram_we),   32'd0);
    check("rst2_spr_valid", 32'(bus.spr_valid), 32'd0);
    check("rst2_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    s0 = n_sprv;
    repeat (5) tick();
    check("rst2_no_spr_valid", 32'(n_sprv - s0), 32'd0);

    // random traffic: a light-bg mix and a spr-heavy mix that starves the CPU
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2500; i++) begin
        bus.bg_req   = (ph == 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
        bus.bg_addr  = AW'($urandom);
        bus.spr_req  = (ph == 0) ? ($urandom % 2 == 0) : ($urandom % 10 != 0);
        bus.spr_addr = AW'($urandom % 64);
        if (bus.cpu_req) begin
          if (ack_seen) bus.cpu_req = 0;
        end else if ($urandom % 4 == 0) begin
          bus.cpu_req   = 1;
          bus.cpu_we    = 1'($urandom % 2);
          bus.cpu_addr  = AW'($urandom % 64);
          bus.cpu_wdata = 8'($urandom);
        end
        tick();
      end
      idle();
      repeat (4) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdp_vram_arbiter.md
VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, VRAM address width.
REQ-002 Parameter STARVE_LIMIT, default 32, CPU wait cycles before CPU outranks sprite.
REQ-003 clk  in  1  system clock; the block is single-clock and every register updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 bg_req  in  1  background fetcher requests a read this cycle.
REQ-006 bg_addr  in  ADDR_W  background read address.
REQ-007 bg_valid  out  1  pulse: vram_d holds data for the background request.
REQ-008 spr_req  in  1  sprite fetcher requests a read.
REQ-009 spr_addr  in  ADDR_W  sprite read address.
REQ-010 spr_valid  out  1  pulse: vram_d holds data for the sprite request.
REQ-011 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-012 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-013 cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
REQ-014 cpu_wdata  in  8  CPU write data.
REQ-015 cpu_ack  out  1  one-cycle completion pulse.
REQ-016 cpu_rdata  out  8  CPU read data, valid while cpu_ack is high and held until the next CPU read ack.
REQ-017 vram_a  out  ADDR_W  registered VRAM address.
REQ-018 vram_we  out  1  registered VRAM write enable.
REQ-019 vram_wdata  out  8  registered VRAM write data.
REQ-020 vram_d  in  8  VRAM read data, valid one cycle after vram_a.

Function
REQ-021 Each cycle the arbiter SHALL grant at most one requester, sampling the requests combinationally; vram_a, vram_we and vram_wdata SHALL be registered on the next edge.
REQ-022 Priority SHALL be: bg > spr > cpu, except that when starve_cnt >= STARVE_LIMIT the order SHALL become bg > cpu > spr.
REQ-023 bg SHALL always win; a bg_req is never stalled, and the bg fetch pipeline relies on this.
REQ-024 The grant owner {NONE, BG, SPR, CPU, including the CPU we bit} SHALL be pipelined two stages to track the VRAM latency.
REQ-025 The matching strobe (bg_valid, spr_valid or cpu_ack) SHALL assert exactly 2 cycles after the granted request cycle; request-to-data latency is 2 cycles.
REQ-026 A CPU write SHALL drive vram_we=1 for exactly one cycle; cpu_ack SHALL assert 2 cycles after the grant, with the same timing as a read.
REQ-027 After a CPU grant, the arbiter SHALL NOT re-grant the CPU until cpu_ack has pulsed, which prevents double issue of a held request.
REQ-028 starve_cnt SHALL increment each cycle that cpu_req=1 and no CPU grant is pending; it SHALL saturate at STARVE_LIMIT and clear on the CPU grant.
REQ-029 With no grant, vram_we SHALL be 0 and vram_a SHALL hold its previous value.
REQ-030 Simultaneous bg_req, spr_req and cpu_req with the CPU starved: bg is granted; the CPU goes next free cycle, ahead of spr.
REQ-031 Dropping cpu_req before cpu_ack is a protocol violation; the arbiter SHALL still complete the access already granted.

Reset
REQ-032 While rst is high, the arbiter SHALL drive: vram_a=0, vram_we=0, vram_wdata=0, bg_valid=0, spr_valid=0, cpu_ack=0, cpu_rdata=0, pipeline owners=NONE, starve_cnt=0, CPU pending flag=0.
REQ-033 Reset mid-access SHALL discard in-flight grants; no strobe SHALL be emitted for them after rst deasserts.
REQ-034 The first grant SHALL be possible in the cycle after rst deasserts.

Structure
REQ-035 The owner enum (OWN_NONE, OWN_BG, OWN_SPR, OWN_CPU) and the default STARVE_LIMIT SHALL live in the shared vdp_pkg.
REQ-036 The block SHALL be implemented flat, with no sub-module; the priority select and the owner pipeline are inline.

Verification
REQ-037 bg_req=1 at bg_addr=0x0100 for one cycle -> vram_a=0x0100 next cycle; bg_valid=1 two cycles after the request, with vram_d from the model.
REQ-038 cpu_req write, addr 0x3F00, data 0xA5, all others idle -> exactly one vram_we pulse at 0x3F00 with data 0xA5; cpu_ack 2 cycles after the request; a later CPU read of 0x3F00 returns cpu_rdata=0xA5.
REQ-039 bg_req and spr_req held continuously high, plus a CPU read -> no CPU grant while bg_req is high.
REQ-040 spr_req held high, bg idle, plus a CPU read -> CPU granted after exactly 32 waiting cycles; starve_cnt returns to 0 and spr resumes the cycle after.
REQ-041 cpu_req held high 10 cycles with nothing else requesting -> exactly one grant and one cpu_ack.
REQ-042 rst asserted 1 cycle after a spr grant -> spr_valid never pulses; all outputs are at reset values the cycle after rst asserts.
